inst_sequencer: RTL and testbench

INST_SEQUENCER -- requirements
Module: inst_sequencer

---
 rtl/inst_sequencer_pkg.sv | 12 +
 rtl/inst_sequencer_pc_next.sv | 17 +
 rtl/inst_sequencer.sv | 76 +++++++
 tb/tb_inst_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/inst_sequencer_pkg.sv
// inst_sequencer_pkg: state encoding, instruction format and condition/compare codes.
package inst_sequencer_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_EXEC, S_FAULT} state_t;
  localparam logic [1:0] FMT_BRANCH = 2'b10;
  localparam logic [1:0] COND_EQ = 2'b00, COND_GT = 2'b01, COND_LT = 2'b10, COND_NEVER = 2'b11;
  localparam logic [1:0] CMP_EQ = 2'b00, CMP_GT = 2'b01, CMP_LT = 2'b10, CMP_NONE = 2'b11;
  function automatic logic cond_met(input logic [1:0] cond, input logic [1:0] cmp);
    return cond != COND_NEVER && cmp != CMP_NONE &&
           ((cond == COND_EQ && cmp == CMP_EQ) || (cond == COND_GT && cmp == CMP_GT) ||
            (cond == COND_LT && cmp == CMP_LT));
  endfunction
endpackage

// File: rtl/inst_sequencer_pc_next.sv
// pc_next: branch resolution, selects branch target or pc+1 (wrapping).
module pc_next
  import inst_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [1:0]        i_fmt,
  input  logic [1:0]        i_cond,
  input  logic [ADDR_W-1:0] i_target,
  input  logic [1:0]        i_cmp,
  input  logic [ADDR_W-1:0] i_pc,
  output logic [ADDR_W-1:0] o_next_pc
);
  logic w_taken;
  assign w_taken   = i_fmt == FMT_BRANCH && cond_met(i_cond, i_cmp);
  assign o_next_pc = w_taken ? i_target : i_pc + 1'b1;
endmodule

// File: rtl/inst_sequencer.sv
// inst_sequencer: fetch/load/issue/exec controller that hands instructions to the core
// and advances pc on completion, with stop-after-instruction and an EXEC watchdog.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       d_inst,
  output logic              run,
  input  logic              done,
  input  logic [1:0]        cmp,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fault
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_next_pc;
  logic [15:0]       r_d_inst;
  logic              r_stop_pend;
  logic [CW-1:0]     r_cnt;
  logic              w_retire, w_expired;
  assign w_retire  = r_state == S_EXEC && done;
  // done in the final allowed cycle still retires normally
  assign w_expired = r_state == S_EXEC && !done && r_cnt == CW'(TIMEOUT - 1);
  pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .i_fmt    (r_d_inst[1:0]),
    .i_cond   (r_d_inst[3:2]),
    .i_target (r_d_inst[ADDR_W+3:4]),
    .i_cmp    (cmp),
    .i_pc     (r_pc),
    .o_next_pc(w_next_pc)
  );
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = start ? S_FETCH : S_IDLE;
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = w_retire ? ((r_stop_pend || stop) ? S_IDLE : S_FETCH) :
                             w_expired ? S_FAULT : S_EXEC;
      default: w_state_nxt = r_state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_d_inst    <= '0;
      r_stop_pend <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_d_inst    <= r_state == S_LOAD ? mem_rdata : r_d_inst;
      r_pc        <= w_retire ? w_next_pc : r_pc;
      r_cnt       <= r_state == S_ISSUE ? '0 : r_state == S_EXEC ? r_cnt + 1'b1 : r_cnt;
      r_stop_pend <= w_retire ? 1'b0 : (r_state != S_IDLE && stop) ? 1'b1 : r_stop_pend;
    end
  end
  assign mem_en   = r_state == S_FETCH;
  assign mem_addr = r_pc;
  assign pc       = r_pc;
  assign d_inst   = r_d_inst;
  assign run      = r_state == S_ISSUE;
  assign busy     = r_state != S_IDLE && r_state != S_FAULT;
  assign fault    = r_state == S_FAULT;
endmodule

// File: tb/tb_inst_sequencer.sv
// tb_inst_sequencer: table vectors, directed corner sequences and random programs
// checked against an instruction-level pc model.
module tb_inst_sequencer;
  localparam int TO = 15;
  logic        clk, reset, start, stop, mem_en, run, done, busy, fault;
  logic [7:0]  mem_addr, pc, m_pc, tgt;
  logic [15:0] mem_rdata, d_inst, r_inst;
  logic [1:0]  cmp, r_c;
  logic [15:0] mem [256];
  int          n_chk = 0, n_fail = 0;
  bit          ok;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] inst;
    logic [1:0]  c;
    logic [7:0]  exp;
  } vec_t;
  vec_t vt[12];

  inst_sequencer #(.ADDR_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mem_en(mem_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .d_inst(d_inst), .run(run),
    .done(done), .cmp(cmp), .pc(pc), .busy(busy), .fault(fault)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] ref_next(input logic [7:0] p, input logic [15:0] i, input logic [1:0] c);
    int cond;
    bit taken;
    cond  = int'(i[3:2]);
    taken = (i[1:0] == 2'b10) && cond != 3 && cond == int'(c);
    return taken ? i[11:4] : 8'((int'(p) + 1) % 256);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_run(output bit got);
    got = 0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (mem_en) chk("fetch_addr", 32'(mem_addr), 32'(m_pc));
      if (run) got = 1;
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL run_timeout: got no run expected run within 12 cycles");
    end
  endtask

  // called at the negedge where run is high; stp: 0 none, 1 stop early in EXEC, 2 stop with done
  task automatic finish_inst(input logic [15:0] inst, input logic [1:0] c, input int dly, input int stp);
    chk("run_pc", 32'(pc), 32'(m_pc));
    chk("run_inst", 32'(d_inst), 32'(inst));
    for (int k = 1; k <= dly; k++) begin
      @(negedge clk);
      stop = (stp != 0) && (k == (stp == 1 ? 1 : dly));
      done = (k == dly);
      cmp  = c;
      chk("exec_hold", 32'({run, d_inst}), 32'({1'b0, inst}));
    end
    m_pc = ref_next(m_pc, inst, c);
    @(negedge clk);
    done = 0;
    stop = 0;
    cmp  = 2'($urandom);
    chk("pc_after", 32'(pc), 32'(m_pc));
    if (stp != 0) chk("halt_idle", 32'({busy, mem_en}), 0);
    else chk("refetch", 32'({mem_en, mem_addr}), 32'({1'b1, m_pc}));
  endtask

  task automatic do_inst(input logic [15:0] inst, input logic [1:0] c, input int dly, input int stp);
    bit g;
    mem[m_pc] = inst;
    wait_run(g);
    if (g) finish_inst(inst, c, dly, stp);
  endtask

  task automatic steer(input logic [7:0] p);
    do_inst({4'h0, p, 4'b0010}, 2'b00, 1, 0);
  endtask

  initial begin
    vt[0]  = '{8'h05, 16'h0A02, 2'b00, 8'hA0};
    vt[1]  = '{8'h05, 16'h0A02, 2'b01, 8'h06};
    vt[2]  = '{8'h10, 16'h0376, 2'b01, 8'h37};
    vt[3]  = '{8'h10, 16'h0376, 2'b00, 8'h11};
    vt[4]  = '{8'h20, 16'h0F4A, 2'b10, 8'hF4};
    vt[5]  = '{8'h20, 16'h0F4A, 2'b11, 8'h21};
    vt[6]  = '{8'h30, 16'h0C8E, 2'b11, 8'h31};
    vt[7]  = '{8'h30, 16'h0C8E, 2'b00, 8'h31};
    vt[8]  = '{8'hFF, 16'h0001, 2'b00, 8'h00};
    vt[9]  = '{8'hFE, 16'h0552, 2'b00, 8'h55};
    vt[10] = '{8'h40, 16'h1233, 2'b00, 8'h41};
    vt[11] = '{8'hFF, 16'h0002, 2'b01, 8'h00};
    for (int i = 0; i < 256; i++) mem[i] = '0;
    stop = 0; done = 0; cmp = 0; reset = 1; start = 1; m_pc = 0;
    mem[0] = 16'h2001;
    repeat (2) @(negedge clk);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_inst", 32'(d_inst), 0);
    chk("rst_ctl", 32'({run, mem_en, busy, fault}), 0);
    reset = 0;
    chk("c0_idle", 32'(busy), 0);
    @(negedge clk) chk("c1_fetch", 32'({mem_en, mem_addr}), 32'({1'b1, 8'h00}));
    @(negedge clk) chk("c2_load", 32'({mem_en, run}), 0);
    @(negedge clk) chk("c3_run", 32'(run), 1);
    finish_inst(16'h2001, 2'b11, 3, 0);
    steer(8'h05);
    do_inst(16'h0A02, 2'b00, 2, 0);
    chk("br_taken", 32'(pc), 32'h A0);
    steer(8'h05);
    do_inst(16'h0A02, 2'b01, 2, 0);
    chk("br_not_taken", 32'(pc), 32'h06);
    steer(8'hFF);
    do_inst(16'h0001, 2'b00, 1, 0);
    chk("pc_wrap", 32'(pc), 0);
    foreach (vt[i]) begin
      steer(vt[i].pc);
      do_inst(vt[i].inst, vt[i].c, 2, 0);
      chk("vec_pc", 32'(pc), 32'(vt[i].exp));
    end
    do_inst(16'h1231, 2'b00, TO, 0);
    chk("done_at_timeout", 32'(fault), 0);
    // stop before done halts; stop in IDLE is ignored; start resumes at next pc
    start = 0;
    do_inst(16'h0101, 2'b11, 4, 1);
    repeat (3) begin
      @(negedge clk) chk("halt_no_fetch", 32'({mem_en, busy}), 0);
    end
    stop = 1;
    @(negedge clk) stop = 0;
    start = 1;
    do_inst(16'h0041, 2'b00, 2, 0);
    start = 0;
    do_inst(16'h0033, 2'b00, 3, 2);
    @(negedge clk) chk("halt_coincide", 32'({mem_en, busy}), 0);
    start = 1;
    for (int i = 0; i < 40; i++) begin
      r_inst = 16'($urandom);
      if ($urandom_range(1, 0) == 1) r_inst[1:0] = 2'b10;
      r_c = 2'($urandom);
      do_inst(r_inst, r_c, int'($urandom_range(TO, 1)), 0);
    end
    // watchdog: core never completes
    tgt = 8'h77;
    steer(tgt);
    mem[m_pc] = 16'h0013;
    wait_run(ok);
    repeat (TO) @(negedge clk);
    chk("to_exec", 32'({fault, busy}), 32'b01);
    @(negedge clk);
    chk("to_fault", 32'({fault, busy}), 32'b10);
    chk("to_pc", 32'(pc), 32'(m_pc));
    done = 1;
    @(negedge clk) done = 0;
    @(negedge clk) chk("fault_hold", 32'({fault, run, pc}), 32'({2'b10, m_pc}));
    reset = 1;
    @(negedge clk) reset = 0;
    chk("fault_clr", 32'({fault, pc}), 0);
    m_pc = 0;
    steer(8'h33);
    mem[m_pc] = 16'h0011;
    wait_run(ok);
    @(negedge clk);
    start = 0;
    reset = 1;
    @(negedge clk) chk("rst_exec", 32'({pc, run, busy}), 0);
    reset = 0;
    done = 1;
    @(negedge clk) done = 0;
    chk("late_done", 32'({pc, run, busy}), 0);
    repeat (3) begin
      @(negedge clk) chk("no_run_after_rst", 32'({run, mem_en}), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
